// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
package imem_stream_loader_pkg;

  // Loader FSM encodings, kept in a 3-bit state register.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Byte lane indices within a 32-bit word (lane 0 lands in bits 31:24).
  localparam logic [1:0] LANE_0    = 2'd0;
  localparam logic [1:0] LANE_1    = 2'd1;
  localparam logic [1:0] LANE_2    = 2'd2;
  localparam logic [1:0] LANE_LAST = 2'd3;

  // Fill value for unused lanes of a partial final word.
  localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

endpackage

// File: rtl/imem_stream_loader_byte_word_packer.sv
// Collects stream bytes into a big-endian 32-bit word. The emitted word
// includes the byte being accepted this cycle, so the parent can register
// it directly and write one cycle after the final byte is accepted.
module byte_word_packer
  import imem_stream_loader_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
  input  logic        Clk,
  input  logic        R,
  input  logic        clr_i,
  input  logic        acc_i,
  input  logic        last_i,
  input  logic [7:0]  data_i,
  output logic        emit_o,
  output logic [31:0] word_o
);

  logic [1:0]      lane_q;
  logic [3:0][7:0] buf_q;

  // Word completes on the fourth byte or on an early last byte.
  assign emit_o = acc_i & ((lane_q == LANE_LAST) | last_i);

  // Lane counter and byte buffer; a gap (acc_i=0) leaves both untouched.
  always_ff @(posedge Clk) begin
    if (!R || clr_i) begin
      lane_q <= LANE_0;
      buf_q  <= '0;
    end else if (acc_i) begin
      buf_q[lane_q] <= data_i;
      lane_q        <= emit_o ? LANE_0 : lane_q + 2'd1;
    end
  end

  // Per lane: stored byte, the byte arriving now, or pad above it.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] L = 2'(g);
    assign word_o[31-8*g -: 8] = (lane_q > L)  ? buf_q[g] :
                                 (lane_q == L) ? data_i   : PAD_BYTE;
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Synthesizable instruction-memory loader: packs a byte stream into words,
// writes them from address 0 upward and holds the core until the image is in.
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int         ADDR_W      = 9,
  parameter int         DEPTH_BYTES = 512,
  parameter logic [7:0] PAD_BYTE    = PAD_BYTE_DEF
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              Start,
  input  logic              In_Valid,
  input  logic [7:0]        In_Data,
  input  logic              In_Last,
  output logic              In_Ready,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Data,
  output logic              Core_Hold,
  output logic              Done,
  output logic              Ovf,
  output logic [ADDR_W-2:0] Word_Count
);

  localparam int              WC_W      = ADDR_W - 1;
  localparam logic [WC_W-1:0] MAX_WORDS = WC_W'(DEPTH_BYTES / 4);

  state_t              state_q, state_d;
  logic [WC_W-1:0]     wc_q, wc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                start_load;
  logic                accept, full, pk_acc, pk_emit;
  logic [31:0]         pk_word;

  assign accept = In_Valid & In_Ready;
  // Word count doubles as the write pointer; at MAX_WORDS memory is full.
  assign full   = (wc_q == MAX_WORDS);
  // A byte arriving with memory full is dropped, not buffered.
  assign pk_acc = accept & ~full;

  byte_word_packer #(.PAD_BYTE(PAD_BYTE)) u_packer (
    .Clk    (Clk),
    .R      (R),
    .clr_i  (start_load),
    .acc_i  (pk_acc),
    .last_i (In_Last),
    .data_i (In_Data),
    .emit_o (pk_emit),
    .word_o (pk_word)
  );

  // Handshake and status are pure decodes of the state.
  assign In_Ready   = (state_q == S_LOAD);
  assign Core_Hold  = (state_q != S_DONE);
  assign Done       = (state_q == S_DONE);
  assign Ovf        = (state_q == S_ERR);
  assign Mem_WE     = we_q;
  assign Mem_Addr   = addr_q;
  assign Mem_Data   = data_q;
  assign Word_Count = wc_q;

  // Next-state, pointer and write-port logic. FLUSH covers the cycle the
  // final write is on the bus, so Done rises only after it has landed.
  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    start_load = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d    = S_LOAD;
          wc_d       = '0;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept && full) begin
          state_d = S_ERR;
        end else if (pk_emit) begin
          we_d   = 1'b1;
          addr_d = {wc_q[ADDR_W-3:0], 2'b00};
          data_d = pk_word;
          wc_d   = wc_q + 1'b1;
          if (In_Last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State and write-port registers; reset aborts any load in progress.
  always_ff @(posedge Clk) begin
    if (!R) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench: a full-size loader and an 8-byte loader share one stream.
module tb_imem_stream_loader;

  logic        Clk = 1'b0;
  logic        R = 1'b0;
  logic        Start = 1'b0;
  logic        In_Valid = 1'b0;
  logic [7:0]  In_Data = 8'h00;
  logic        In_Last = 1'b0;

  logic        m_rdy, m_we, m_hold, m_done, m_ovf;
  logic [8:0]  m_addr;
  logic [31:0] m_data;
  logic [7:0]  m_wc;
  logic        s_rdy, s_we, s_hold, s_done, s_ovf;
  logic [8:0]  s_addr;
  logic [31:0] s_data;
  logic [7:0]  s_wc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  m_wa[$];
  logic [31:0] m_wd[$];
  logic [8:0]  s_wa[$];
  logic [31:0] s_wd[$];

  always #5 Clk = ~Clk;

  imem_stream_loader #(.ADDR_W(9), .DEPTH_BYTES(512)) dut (
    .Clk(Clk), .R(R), .Start(Start), .In_Valid(In_Valid), .In_Data(In_Data),
    .In_Last(In_Last), .In_Ready(m_rdy), .Mem_WE(m_we), .Mem_Addr(m_addr),
    .Mem_Data(m_data), .Core_Hold(m_hold), .Done(m_done), .Ovf(m_ovf),
    .Word_Count(m_wc)
  );

  imem_stream_loader #(.ADDR_W(9), .DEPTH_BYTES(8)) dut8 (
    .Clk(Clk), .R(R), .Start(Start), .In_Valid(In_Valid), .In_Data(In_Data),
    .In_Last(In_Last), .In_Ready(s_rdy), .Mem_WE(s_we), .Mem_Addr(s_addr),
    .Mem_Data(s_data), .Core_Hold(s_hold), .Done(s_done), .Ovf(s_ovf),
    .Word_Count(s_wc)
  );

  // Write logs, one entry per Mem_WE cycle.
  always @(posedge Clk) if (m_we === 1'b1) begin m_wa.push_back(m_addr); m_wd.push_back(m_data); end
  always @(posedge Clk) if (s_we === 1'b1) begin s_wa.push_back(s_addr); s_wd.push_back(s_data); end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_logs();
    m_wa.delete(); m_wd.delete(); s_wa.delete(); s_wd.delete();
  endtask

  task automatic do_reset();
    @(negedge Clk); R = 1'b0; Start = 1'b0; In_Valid = 1'b0; In_Last = 1'b0;
    repeat (2) @(negedge Clk);
    R = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    In_Valid = 1'b0; In_Data = 8'hFF; In_Last = (gap > 0);
    repeat (gap) @(negedge Clk);
    In_Valid = 1'b1; In_Data = d; In_Last = last;
    @(negedge Clk);
    In_Valid = 1'b0; In_Last = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", m_we); end
    n_cmp++; if (m_addr !== 9'd0) begin n_bad++; $display("FAIL rst_addr got %h want 0", m_addr); end
    n_cmp++; if (m_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", m_data); end
    n_cmp++; if (m_wc !== 8'd0) begin n_bad++; $display("FAIL rst_wc got %0d want 0", m_wc); end
    n_cmp++; if ({m_done, m_ovf, m_hold, m_rdy} !== 4'b0010) begin n_bad++; $display("FAIL rst_status got done/ovf/hold/rdy=%b want 0010", {m_done, m_ovf, m_hold, m_rdy}); end
    R = 1'b1;
    @(negedge Clk);
    n_cmp++; if (m_we !== 1'b0 || m_rdy !== 1'b0) begin n_bad++; $display("FAIL idle_quiet got we=%b rdy=%b want 0 0", m_we, m_rdy); end
  endtask

  task automatic run_8byte(input string tag, input bit gaps);
    logic [7:0] img [8];
    img = '{8'h8A, 8'h10, 8'h20, 8'h05, 8'h82, 8'h00, 8'h60, 8'h01};
    do_reset();
    pulse_start();
    n_cmp++; if (m_rdy !== 1'b1) begin n_bad++; $display("FAIL %s_ready got %b want 1", tag, m_rdy); end
    for (int i = 0; i < 8; i++)
      send_byte(img[i], i == 7, gaps ? int'($urandom_range(0, 5)) : 0);
    n_cmp++; if (m_we !== 1'b1 || m_done !== 1'b0) begin n_bad++; $display("FAIL %s_flush got we=%b done=%b want 1 0", tag, m_we, m_done); end
    @(negedge Clk);
    n_cmp++; if (m_done !== 1'b1 || m_hold !== 1'b0) begin n_bad++; $display("FAIL %s_done got done=%b hold=%b want 1 0", tag, m_done, m_hold); end
    n_cmp++; if (m_wc !== 8'd2) begin n_bad++; $display("FAIL %s_wc got %0d want 2", tag, m_wc); end
    n_cmp++; if (m_wa.size() != 2) begin n_bad++; $display("FAIL %s_nwr got %0d want 2", tag, m_wa.size()); end
    else begin
      n_cmp++; if (m_wa[0] !== 9'd0 || m_wd[0] !== 32'h8A102005) begin n_bad++; $display("FAIL %s_w0 got %h@%0d want 8a102005@0", tag, m_wd[0], m_wa[0]); end
      n_cmp++; if (m_wa[1] !== 9'd4 || m_wd[1] !== 32'h82006001) begin n_bad++; $display("FAIL %s_w1 got %h@%0d want 82006001@4", tag, m_wd[1], m_wa[1]); end
    end
    // Exact fill of the 8-byte memory with last must finish cleanly.
    n_cmp++; if (s_done !== 1'b1 || s_ovf !== 1'b0) begin n_bad++; $display("FAIL %s_exactfill got done=%b ovf=%b want 1 0", tag, s_done, s_ovf); end
    repeat (3) @(negedge Clk);
    n_cmp++; if (m_wa.size() != 2 || m_done !== 1'b1) begin n_bad++; $display("FAIL %s_idle_done got nwr=%0d done=%b want 2 1", tag, m_wa.size(), m_done); end
  endtask

  task automatic test_contiguous(); run_8byte("contig", 1'b0); endtask
  task automatic test_gaps();       run_8byte("gaps", 1'b1);   endtask

  task automatic test_flush();
    do_reset();
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6, 0);
    n_cmp++; if (m_we !== 1'b1 || m_rdy !== 1'b0) begin n_bad++; $display("FAIL flush_state got we=%b rdy=%b want 1 0", m_we, m_rdy); end
    @(negedge Clk);
    n_cmp++; if (m_done !== 1'b1 || m_wc !== 8'd2) begin n_bad++; $display("FAIL flush_done got done=%b wc=%0d want 1 2", m_done, m_wc); end
    n_cmp++; if (m_wa.size() != 2) begin n_bad++; $display("FAIL flush_nwr got %0d want 2", m_wa.size()); end
    else begin
      n_cmp++; if (m_wa[0] !== 9'd0 || m_wd[0] !== 32'h01020304) begin n_bad++; $display("FAIL flush_w0 got %h@%0d want 01020304@0", m_wd[0], m_wa[0]); end
      n_cmp++; if (m_wa[1] !== 9'd4 || m_wd[1] !== 32'h05060000) begin n_bad++; $display("FAIL flush_w1 got %h@%0d want 05060000@4", m_wd[1], m_wa[1]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] img [9];
    img = '{8'h8A, 8'h10, 8'h20, 8'h05, 8'h82, 8'h00, 8'h60, 8'h01, 8'h77};
    do_reset();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0, 0);
    @(negedge Clk);
    n_cmp++; if (s_rdy !== 1'b1 || s_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_fullwait got rdy=%b ovf=%b want 1 0", s_rdy, s_ovf); end
    send_byte(img[8], 1'b0, 0);
    n_cmp++; if ({s_ovf, s_hold, s_done, s_rdy} !== 4'b1100) begin n_bad++; $display("FAIL ovf_err got ovf/hold/done/rdy=%b want 1100", {s_ovf, s_hold, s_done, s_rdy}); end
    n_cmp++; if (s_wa.size() != 2) begin n_bad++; $display("FAIL ovf_nwr got %0d want 2", s_wa.size()); end
    else begin
      n_cmp++; if (s_wd[0] !== 32'h8A102005 || s_wd[1] !== 32'h82006001 || s_wa[1] !== 9'd4) begin n_bad++; $display("FAIL ovf_words got %h %h@%0d want 8a102005 82006001@4", s_wd[0], s_wd[1], s_wa[1]); end
    end
    pulse_start();
    repeat (3) @(negedge Clk);
    n_cmp++; if ({s_ovf, s_hold, s_done, s_rdy} !== 4'b1100 || s_wa.size() != 2) begin n_bad++; $display("FAIL ovf_sticky got ovf/hold/done/rdy=%b nwr=%0d want 1100 2", {s_ovf, s_hold, s_done, s_rdy}, s_wa.size()); end
    do_reset();
    n_cmp++; if (s_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", s_ovf); end
  endtask

  task automatic test_abort();
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1'b0, 0);
    R = 1'b0;
    @(negedge Clk);
    n_cmp++; if ({m_we, m_done, m_ovf, m_hold, m_rdy} !== 5'b00010 || m_wc !== 8'd0 || m_addr !== 9'd0 || m_data !== 32'd0) begin
      n_bad++; $display("FAIL abort_rst got we/done/ovf/hold/rdy=%b wc=%0d addr=%0d data=%h want 00010 0 0 0", {m_we, m_done, m_ovf, m_hold, m_rdy}, m_wc, m_addr, m_data); end
    R = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++; if (m_wa.size() != 1) begin n_bad++; $display("FAIL abort_nwr got %0d want 1", m_wa.size()); end
    clear_logs();
    pulse_start();
    send_byte(8'h11, 1'b0, 0); send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0); send_byte(8'h44, 1'b1, 0);
    @(negedge Clk);
    n_cmp++; if (m_wa.size() != 1 || m_wa[0] !== 9'd0 || m_wd[0] !== 32'h11223344) begin n_bad++; $display("FAIL abort_reload got n=%0d %h want 1 11223344@0", m_wa.size(), m_wd[0]); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    n_cmp++; if (m_done !== 1'b1) begin n_bad++; $display("FAIL b2b_pre got done=%b want 1", m_done); end
    pulse_start();
    n_cmp++; if (m_hold !== 1'b1 || m_done !== 1'b0 || m_wc !== 8'd0) begin n_bad++; $display("FAIL b2b_restart got hold=%b done=%b wc=%0d want 1 0 0", m_hold, m_done, m_wc); end
    send_byte(8'hDE, 1'b0, 0); send_byte(8'hAD, 1'b0, 0);
    send_byte(8'hBE, 1'b0, 0); send_byte(8'hEF, 1'b1, 0);
    @(negedge Clk);
    n_cmp++; if (m_done !== 1'b1 || m_wc !== 8'd1) begin n_bad++; $display("FAIL b2b_done got done=%b wc=%0d want 1 1", m_done, m_wc); end
    n_cmp++; if (m_wa.size() != 1 || m_wa[0] !== 9'd0 || m_wd[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_word got n=%0d %h want 1 deadbeef@0", m_wa.size(), m_wd[0]); end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_flush();
    test_overflow();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
